// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the multiplier datapath and the product accumulator.
package product_accumulator_pkg;

    localparam int unsigned DEF_PROD_W    = 16;
    localparam int unsigned DEF_MAX_TERMS = 8;
    localparam int unsigned DEF_ACC_W     = 19;
    localparam int unsigned DEF_CNT_W     = 4;

    // Accumulator control states
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_acc_adder.sv
// Unsigned ripple-carry adder; carry-out is dropped because the accumulator
// width is sized so a frame total can never overflow it.
module product_accumulator_acc_adder #(
    parameter int unsigned ACC_W = 19
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] carry;

    assign carry[0] = 1'b0;

    // One full-adder cell per bit; bit 0 degenerates to a half adder
    for (genvar i = 0; i < int'(ACC_W); i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < int'(ACC_W) - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule : product_accumulator_acc_adder

// File: rtl/product_accumulator.sv
// Sums a frame of multiplier products and hands the total off on a
// valid/ready output. A frame closes on in_last or after MAX_TERMS beats.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W    = DEF_PROD_W,
    parameter int unsigned MAX_TERMS = DEF_MAX_TERMS,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_terms
);

    // Parameter sanity: reject sizes that could overflow the sum or the count
    if (MAX_TERMS < 1) begin : g_bad_max_terms
        $error("product_accumulator: MAX_TERMS must be >= 1");
    end
    if (ACC_W < PROD_W + $clog2(MAX_TERMS)) begin : g_bad_acc_w
        $error("product_accumulator: ACC_W too small for PROD_W and MAX_TERMS");
    end
    if (CNT_W < $clog2(MAX_TERMS + 1)) begin : g_bad_cnt_w
        $error("product_accumulator: CNT_W too small for MAX_TERMS");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_d;
    logic [CNT_W-1:0] terms_d;
    logic             valid_d;
    logic             ready_d;
    logic [ACC_W-1:0] add_sum;
    logic             accept;

    assign accept = in_valid & in_ready;

    // Running sum plus the zero-extended incoming product
    product_accumulator_acc_adder #(
        .ACC_W (ACC_W)
    ) u_acc_adder (
        .a   (acc_q),
        .b   (ACC_W'(in_product)),
        .sum (add_sum)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sum   <= '0;
            out_terms <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sum   <= sum_d;
            out_terms <= terms_d;
            out_valid <= valid_d;
            in_ready  <= ready_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = out_sum;
        terms_d = out_terms;
        valid_d = out_valid;
        ready_d = in_ready;

        unique case (state_q)
            ACCUM: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    // Closing beat: publish the total and restart from zero
                    if (in_last || (cnt_q == LAST_IDX)) begin
                        sum_d   = add_sum;
                        terms_d = cnt_q + CNT_W'(1);
                        valid_d = 1'b1;
                        ready_d = 1'b0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                ready_d = 1'b0;
                valid_d = 1'b1;
                if (out_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Directed and random frames into product_accumulator; a monitor checks each
// result handshake against a queue of expected frame totals.
module tb_product_accumulator;

    typedef struct packed {
        logic [18:0] sum;
        logic [3:0]  terms;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [18:0] out_sum;
    logic [3:0]  out_terms;

    int   checks = 0;
    int   failures = 0;
    bit   rand_ready = 1'b0;
    exp_t expq[$];

    product_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_terms  (out_terms)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result handshake must match the oldest expected frame
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_frame: got sum %0h terms %0d with nothing expected", out_sum, out_terms);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("frame_sum", 32'(out_sum), 32'(e.sum));
                chk("frame_terms", 32'(out_terms), 32'(e.terms));
            end
        end
    end

    // Random consumer back-pressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; presents one beat until it is accepted
    task automatic beat(input logic [15:0] p, input logic l);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_product = p;
        in_last = l;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [18:0] s, input logic [3:0] t);
        exp_t e;
        e.sum = s;
        e.terms = t;
        return e;
    endfunction

    initial begin
        // Reset state
        idle(3);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_terms", 32'(out_terms), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        chk("ready_after_rst", 32'(in_ready), 1);

        // Full frame of max products with consumer stalled, then 10 cycles of back-pressure
        expq.push_back(mk(19'h7FFF8, 4'd8));
        for (int i = 0; i < 8; i++) beat(16'hFFFF, 1'b0);
        chk("hold_valid_next_cycle", 32'(out_valid), 1);
        chk("hold_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_product = 16'd1234;
        in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_sum_stable", 32'(out_sum), 32'h7FFF8);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        idle(1);
        @(negedge clk);
        chk("released_valid_low", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // Short frame closed by in_last, then a fresh single-term frame
        expq.push_back(mk(19'd15, 4'd3));
        beat(16'd3, 1'b0);
        beat(16'd5, 1'b0);
        beat(16'd7, 1'b1);
        expq.push_back(mk(19'd2, 4'd1));
        beat(16'd2, 1'b1);

        // Gaps in in_valid keep the partial sum
        expq.push_back(mk(19'd600, 4'd3));
        beat(16'd100, 1'b0);
        idle(2);
        beat(16'd200, 1'b0);
        idle(1);
        beat(16'd300, 1'b1);

        // in_last on the 8th beat closes exactly one frame; zero products still count
        expq.push_back(mk(19'd36, 4'd8));
        for (int i = 1; i <= 8; i++) beat(16'(i), i == 8);
        expq.push_back(mk(19'd0, 4'd2));
        beat(16'd0, 1'b0);
        beat(16'd0, 1'b1);
        expq.push_back(mk(19'd5, 4'd1));
        beat(16'd5, 1'b1);
        idle(3);

        // Reset mid-frame: outputs clear immediately
        for (int i = 0; i < 4; i++) beat(16'd1000, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_sum", 32'(out_sum), 0);
        chk("midrst_out_terms", 32'(out_terms), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Reset while holding an undelivered result
        out_ready = 1'b0;
        beat(16'd9, 1'b1);
        chk("pre_rst_hold_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("holdrst_out_valid", 32'(out_valid), 0);
        chk("holdrst_out_sum", 32'(out_sum), 0);
        chk("holdrst_out_terms", 32'(out_terms), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        expq.push_back(mk(19'd2, 4'd1 + 4'd1));
        beat(16'd1, 1'b0);
        beat(16'd1, 1'b1);

        // Random frames of 8x8 products with random back-pressure
        rand_ready = 1'b1;
        for (int f = 0; f < 2200; f++) begin
            int   len;
            logic [18:0] s;
            logic [15:0] prods[8];
            len = int'($urandom_range(1, 8));
            s = '0;
            for (int i = 0; i < len; i++) begin
                logic [7:0] a, b;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                prods[i] = 16'(a) * 16'(b);
                s = s + 19'(prods[i]);
            end
            expq.push_back(mk(s, 4'(len)));
            for (int i = 0; i < len; i++) begin
                logic l;
                l = (i == len - 1) && ((len < 8) || ($urandom_range(0, 1) == 1));
                beat(prods[i], l);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;

        // Drain: every expected frame must have been delivered
        for (int n = 0; n < 100 && expq.size() != 0; n++) @(posedge clk);
        idle(2);
        chk("frames_pending", 32'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_product_accumulator
